// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the MIPS writeback stage.
package wb_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned LT_W       = 3;

  localparam logic [REG_W-1:0] REG_LINK = 5'd31;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [LT_W-1:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2,
    S_DRAIN    = 2'd3
  } state_e;

  // Control fields of one retiring instruction, held while its load is outstanding.
  typedef struct packed {
    logic [REG_W-1:0] reg_dst;
    logic             reg_write;
    logic             link;
    logic [LT_W-1:0]  load_type;
    logic [1:0]       byte_off;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake, load-data return and register-file write port bundle.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_regDst;
  logic              in_regWrite;
  logic              in_memToReg;
  logic              in_link;
  logic [LT_W-1:0]   in_loadType;
  logic [1:0]        in_byteOff;
  logic [DATA_W-1:0] in_aluResult;
  logic [DATA_W-1:0] in_pc;
  logic              flush;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic [REG_W-1:0]  writeReg;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] writeLink;
  logic              regWrite;
  logic              link;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, in_regDst, in_regWrite, in_memToReg, in_link, in_loadType,
           in_byteOff, in_aluResult, in_pc, flush, mem_rvalid, mem_rdata,
    input  in_ready, writeReg, writeData, writeLink, regWrite, link,
           fwd_valid, fwd_reg, fwd_data
  );

  modport slave (
    input  in_valid, in_regDst, in_regWrite, in_memToReg, in_link, in_loadType,
           in_byteOff, in_aluResult, in_pc, flush, mem_rvalid, mem_rdata,
    output in_ready, writeReg, writeData, writeLink, regWrite, link,
           fwd_valid, fwd_reg, fwd_data
  );

endinterface

// File: rtl/wb_stage_load_extend.sv
// Little-endian byte/half selection and sign/zero extension of raw load data.
module wb_stage_load_extend
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [LT_W-1:0]   i_load_type,
  input  logic [1:0]        i_byte_off,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Unlisted load types fall through to a full-word load.
  always_comb begin
    w_byte   = 8'(i_rdata >> {i_byte_off, 3'b000});
    w_half   = 16'(i_rdata >> {i_byte_off[1], 4'b0000});
    o_data_c = i_rdata;
    case (i_load_type)
      LT_LB:   o_data_c = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LT_LBU:  o_data_c = {{(DATA_W-8){1'b0}}, w_byte};
      LT_LH:   o_data_c = {{(DATA_W-16){w_half[15]}}, w_half};
      LT_LHU:  o_data_c = {{(DATA_W-16){1'b0}}, w_half};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: accepts retiring instructions, waits for load data, drives the RF write port.
// Optional retire/flush counters are built when WB_RETIRE_CNT_EN is defined.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LINK_OFFSET = 8
) (
  input  logic        Clk,
  input  logic        reset,
  wb_stage_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [15:0] flush_cnt
`endif
);

  state_e            r_state, w_state_nxt;
  wb_ctrl_t          r_ctrl, w_ctrl_nxt;
  logic [DATA_W-1:0] r_pc, w_pc_nxt;

  logic [REG_W-1:0]  r_write_reg, w_write_reg_nxt;
  logic [DATA_W-1:0] r_write_data, w_write_data_nxt;
  logic [DATA_W-1:0] r_write_link, w_write_link_nxt;
  logic              r_reg_write, w_reg_write_nxt;
  logic              r_link, w_link_nxt;

  logic              w_ready;
  logic              w_accept;
  logic              w_commit;
  wb_ctrl_t          w_in_ctrl;
  wb_ctrl_t          w_src_ctrl;
  logic [DATA_W-1:0] w_src_data;
  logic [DATA_W-1:0] w_src_pc;
  logic [REG_W-1:0]  w_eff_reg;
  logic [DATA_W-1:0] w_ext_data;

  // Ready is forced low while reset is held so every output reads 0 during reset.
  assign w_ready  = reset & ((r_state == S_IDLE) | (r_state == S_COMMIT));
  assign w_accept = bus.in_valid & w_ready & ~bus.flush;

  assign w_in_ctrl = '{
    reg_dst:   bus.in_regDst,
    reg_write: bus.in_regWrite,
    link:      bus.in_link,
    load_type: bus.in_loadType,
    byte_off:  bus.in_byteOff
  };

  wb_stage_load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .i_load_type (r_ctrl.load_type),
    .i_byte_off  (r_ctrl.byte_off),
    .i_rdata     (bus.mem_rdata),
    .o_data_c    (w_ext_data)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ctrl       <= '0;
      r_pc         <= '0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_write_link <= '0;
      r_reg_write  <= 1'b0;
      r_link       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ctrl       <= w_ctrl_nxt;
      r_pc         <= w_pc_nxt;
      r_write_reg  <= w_write_reg_nxt;
      r_write_data <= w_write_data_nxt;
      r_write_link <= w_write_link_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_link       <= w_link_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ctrl_nxt       = r_ctrl;
    w_pc_nxt         = r_pc;
    w_commit         = 1'b0;
    w_src_ctrl       = r_ctrl;
    w_src_data       = w_ext_data;
    w_src_pc         = r_pc;
    w_eff_reg        = REG_ZERO;
    w_write_reg_nxt  = r_write_reg;
    w_write_data_nxt = r_write_data;
    w_write_link_nxt = r_write_link;
    w_reg_write_nxt  = 1'b0;
    w_link_nxt       = 1'b0;

    case (r_state)
      S_IDLE, S_COMMIT: begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          if (bus.in_memToReg) begin
            w_state_nxt = S_WAIT_MEM;
            w_ctrl_nxt  = w_in_ctrl;
            w_pc_nxt    = bus.in_pc;
          end else begin
            w_state_nxt = S_COMMIT;
            w_commit    = 1'b1;
            w_src_ctrl  = w_in_ctrl;
            w_src_data  = bus.in_aluResult;
            w_src_pc    = bus.in_pc;
          end
        end
      end
      // A flush coinciding with the data return retires nothing and skips DRAIN.
      S_WAIT_MEM: begin
        if (bus.flush) begin
          w_state_nxt = bus.mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rvalid) begin
          w_state_nxt = S_COMMIT;
          w_commit    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.mem_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Load the RF port; writes aimed at $0 keep address/data but drop the enable.
    if (w_commit) begin
      w_eff_reg        = w_src_ctrl.link ? REG_LINK : w_src_ctrl.reg_dst;
      w_write_reg_nxt  = w_eff_reg;
      w_write_data_nxt = w_src_data;
      w_write_link_nxt = w_src_pc + DATA_W'(LINK_OFFSET);
      w_reg_write_nxt  = (w_src_ctrl.reg_write | w_src_ctrl.link) & (w_eff_reg != REG_ZERO);
      w_link_nxt       = w_src_ctrl.link;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.writeReg  = r_write_reg;
  assign bus.writeData = r_write_data;
  assign bus.writeLink = r_write_link;
  assign bus.regWrite  = r_reg_write;
  assign bus.link      = r_link;
  assign bus.fwd_valid = r_reg_write;
  assign bus.fwd_reg   = r_write_reg;
  assign bus.fwd_data  = r_link ? r_write_link : r_write_data;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;
  logic [15:0] r_flush_cnt;

  // Retire count wraps; flush count saturates and only sees flushes of a pending load.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_retire_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (r_state == S_COMMIT) r_retire_cnt <= r_retire_cnt + 32'd1;
      if ((r_state == S_WAIT_MEM) && bus.flush && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the MIPS pipeline; the producer side of the register file write port.
- Accepts retiring instructions from MEM over a valid/ready handshake and waits for load data when needed.
- Sign/zero-extends load data and drives the register file's writeReg/writeData/writeLink/regWrite/link inputs, one commit per instruction.
- Outputs are registered on posedge Clk; the register file samples them on the following negedge.

Parameters:
- DATA_W, 32, datapath width.
- LINK_OFFSET, 8, added to in_pc to form the link value (PC+8, delay slot).

Ports:
- Clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  MEM stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_regDst  input  5  destination register.
- in_regWrite  input  1  instruction writes a GPR.
- in_memToReg  input  1  result comes from load data.
- in_link  input  1  jal/jalr/bgezal-type link write.
- in_loadType  input  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU.
- in_byteOff  input  2  low address bits of the load.
- in_aluResult  input  DATA_W  ALU result.
- in_pc  input  DATA_W  instruction PC.
- flush  input  1  discard the in-flight instruction.
- mem_rvalid  input  1  load data valid (single-cycle pulse).
- mem_rdata  input  DATA_W  raw load word.
- writeReg  output  5  register file write address.
- writeData  output  DATA_W  register file write data.
- writeLink  output  DATA_W  link value.
- regWrite  output  1  register file write enable.
- link  output  1  link write qualifier.
- fwd_valid  output  1  forwarding source valid (equals regWrite).
- fwd_reg  output  5  forwarding register (equals writeReg).
- fwd_data  output  DATA_W  forwarding value (writeLink if link, else writeData).

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-operation abandons any pending load; a mem_rvalid after reset deasserts is ignored.
- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
  - COMMIT: in_ready=1.
  - DRAIN: in_ready=0.
- Accept (in_valid & in_ready & ~flush):
  - in_memToReg=1 goes to WAIT_MEM.
  - Otherwise goes to COMMIT next cycle with outputs loaded.
  - Non-load throughput is 1/cycle: COMMIT may accept back-to-back.
- WAIT_MEM:
  - mem_rvalid goes to COMMIT with writeData = extended mem_rdata.
  - flush goes to DRAIN; if mem_rvalid is also high that cycle, go to IDLE instead with no write.
- DRAIN: wait for mem_rvalid, then go to IDLE; no write.
- COMMIT:
  - regWrite=1 for exactly one cycle if (in_regWrite | in_link) and the effective destination is not 0.
  - Writes to $0 are suppressed: regWrite=0, with writeReg/writeData still loaded.
  - Leaves to IDLE, or to the next accepted instruction's state.
- Link: writeReg=31, link=1, writeLink=in_pc+LINK_OFFSET (mod 2^32); writeData is don't-care but driven to in_aluResult.
- Load extension (little-endian):
  - LB/LBU select byte in_byteOff; LH/LHU select half in_byteOff[1]; in_byteOff[0] is ignored.
  - LW ignores in_byteOff.
  - Sign or zero extension per type.
  - loadType values 5-7 are treated as LW.
- flush in IDLE/COMMIT blocks acceptance that cycle; the commit already in progress still completes.
- regWrite and link are 0 in every non-COMMIT cycle.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (32-bit), reset 0, incremented once per COMMIT cycle (including $0-suppressed writes), wrapping 0xFFFFFFFF to 0.
  - Adds output flush_cnt (16-bit, saturating), counting flushes that hit WAIT_MEM.
- When undefined: both ports and all associated logic are absent.

Decomposition:
- Shared package holds:
  - load type encodings LT_LW/LT_LB/LT_LBU/LT_LH/LT_LHU;
  - state encodings S_IDLE/S_WAIT_MEM/S_COMMIT/S_DRAIN;
  - REG_LINK=31 and REG_ZERO=0.
- One natural combinational sub-module, load_extend (loadType, byteOff, rdata to extended data).

Test Plan:
- Reset low mid-WAIT_MEM, then release, then mem_rvalid pulse -> all outputs 0, no regWrite pulse, state IDLE.
- Three back-to-back ALU ops (regDst 4/5/6, aluResult 1/2/3) -> in_ready stays 1; regWrite high three consecutive cycles; writeReg 4,5,6; writeData 1,2,3.
- LB, byteOff=2, mem_rdata=0x12F45678 after 3 wait cycles -> in_ready=0 during the wait; writeData=0xFFFFFFF4. LBU with the same stimulus -> 0x000000F4. LH, byteOff=2 -> 0x000012F4.
- jal with in_pc=0x00400010, in_link=1 -> writeReg=31, link=1, writeLink=0x00400018, fwd_data=0x00400018.
- ALU op with regDst=0, regWrite=1 -> regWrite=0, fwd_valid=0.
- Load, then flush during WAIT_MEM, then mem_rvalid 2 cycles later -> no write; in_ready returns to 1 the cycle after mem_rvalid; flush_cnt=1 when WB_RETIRE_CNT_EN is defined.
